mcp3002_spi_responder: RTL and testbench

- Synthesizable SPI responder that emulates the MCP3002 2-channel 10-bit ADC.
- Lets the data-logger's ADC master be exercised on-board or in simulation without the real chip.
- Samples CS/SCLK/DIN from the master on the system clock, decodes start/SGL/ODD/MSBF, and shifts back a null bit plus the 10-bit code taken from ch0_data or ch1_data.
- Sits between a test-pattern source (or loopback) and the master's pins.

---
 rtl/mcp3002_spi_if.sv | 12 +
 rtl/mcp3002_spi_responder.sv | 196 +++++++++++++++++++
 tb/tb_mcp3002_spi_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mcp3002_spi_if.sv
// SPI pin bundle between an MCP3002-style ADC master and the responder.
// The master drives cs/sclk/din; the responder drives dout and its pad enable.
interface mcp3002_spi_if;
  logic cs;
  logic sclk;
  logic din;
  logic dout;
  logic dout_en;

  modport master (output cs, sclk, din, input dout, dout_en);
  modport slave  (input cs, sclk, din, output dout, dout_en);
endinterface

// File: rtl/mcp3002_spi_responder.sv
// MCP3002 emulation: oversamples the master's SPI pins on clk, decodes the
// start/SGL/ODD/MSBF header and shifts back a null bit plus a 10-bit code.
module mcp3002_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  mcp3002_spi_if.slave      spi,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              sample_strobe,
  output logic              cfg_sgl,
  output logic              cfg_odd,
  output logic              cfg_msbf,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, CFG, NULL_BIT, DATA, LSBF, TRAIL
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, din_s;
  logic                   cs_fall, sclk_rise, sclk_fall;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    msb_idx;
  logic                sgl_tmp_q, sgl_tmp_d, odd_tmp_q, odd_tmp_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   sel_value;
  logic [DATA_W:0]     diff;
  logic                cfg_sgl_q, cfg_sgl_d, cfg_odd_q, cfg_odd_d, cfg_msbf_q, cfg_msbf_d;
  logic                dout_q, dout_d, dout_en_q, dout_en_d;
  logic                strobe_q, strobe_d, done_q, done_d, err_q, err_d;

  // cs synchronizer resets low so a cs already low at release is not seen
  // as a falling edge; a fresh high-then-low sequence is required.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value, forming a real shift chain.
      cs_sync_q[0]   <= spi.cs;
      sclk_sync_q[0] <= spi.sclk;
      din_sync_q[0]  <= spi.din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync_q[i]   <= cs_sync_q[i-1];
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        din_sync_q[i]  <= din_sync_q[i-1];
      end
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign msb_idx   = CNT_W'(DATA_W - 1) - cnt_q;

  // Differential modes subtract in DATA_W+1 bits; a set top bit means negative -> 0.
  always_comb begin
    diff = odd_tmp_q ? ({1'b0, ch1_data} - {1'b0, ch0_data})
                     : ({1'b0, ch0_data} - {1'b0, ch1_data});
    if (sgl_tmp_q)      sel_value = odd_tmp_q ? ch1_data : ch0_data;
    else if (diff[DATA_W]) sel_value = '0;
    else                sel_value = diff[DATA_W-1:0];
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    sgl_tmp_d  = sgl_tmp_q;
    odd_tmp_d  = odd_tmp_q;
    hold_d     = hold_q;
    cfg_sgl_d  = cfg_sgl_q;
    cfg_odd_d  = cfg_odd_q;
    cfg_msbf_d = cfg_msbf_q;
    dout_d     = dout_q;
    dout_en_d  = dout_en_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (cs_s) begin
      // cs high wins over any coincident sclk edge; abort only counts once B0 is unsampled.
      state_d   = IDLE;
      cnt_d     = '0;
      dout_d    = 1'b0;
      dout_en_d = 1'b0;
      if (state_q inside {CFG, NULL_BIT, DATA}) err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall) state_d = WAIT_START;
        WAIT_START: if (sclk_rise && din_s) begin
          state_d = CFG;
          cnt_d   = '0;
        end
        CFG: if (sclk_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(0))      sgl_tmp_d = din_s;
          else if (cnt_q == CNT_W'(1)) odd_tmp_d = din_s;
          else begin
            hold_d     = sel_value;
            strobe_d   = 1'b1;
            cfg_sgl_d  = sgl_tmp_q;
            cfg_odd_d  = odd_tmp_q;
            cfg_msbf_d = din_s;
            state_d    = NULL_BIT;
          end
        end
        NULL_BIT: if (sclk_fall) begin
          dout_d    = 1'b0;
          dout_en_d = 1'b1;
          cnt_d     = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            if (sclk_rise) begin
              done_d  = 1'b1;
              cnt_d   = CNT_W'(1);
              state_d = cfg_msbf_q ? TRAIL : LSBF;
            end
          end else if (sclk_fall) begin
            dout_d = hold_q[msb_idx];
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        LSBF: if (sclk_fall) begin
          dout_d = hold_q[cnt_q];
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = TRAIL;
          else                             cnt_d   = cnt_q + CNT_W'(1);
        end
        TRAIL: if (sclk_fall) dout_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sgl_tmp_q  <= 1'b0;
      odd_tmp_q  <= 1'b0;
      hold_q     <= '0;
      cfg_sgl_q  <= 1'b0;
      cfg_odd_q  <= 1'b0;
      cfg_msbf_q <= 1'b0;
      dout_q     <= 1'b0;
      dout_en_q  <= 1'b0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sgl_tmp_q  <= sgl_tmp_d;
      odd_tmp_q  <= odd_tmp_d;
      hold_q     <= hold_d;
      cfg_sgl_q  <= cfg_sgl_d;
      cfg_odd_q  <= cfg_odd_d;
      cfg_msbf_q <= cfg_msbf_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign spi.dout      = dout_q;
  assign spi.dout_en   = dout_en_q;
  assign sample_strobe = strobe_q;
  assign cfg_sgl       = cfg_sgl_q;
  assign cfg_odd       = cfg_odd_q;
  assign cfg_msbf      = cfg_msbf_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_mcp3002_spi_responder.sv
// Self-checking bench: an SPI master model drives frames, expected codes are
// queued per frame and compared against the bits sampled on rising sclk.
module tb_mcp3002_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] ch0, ch1;
  logic       sample_strobe, cfg_sgl, cfg_odd, cfg_msbf, frame_done, frame_err;

  mcp3002_spi_if spi();

  mcp3002_spi_responder #(.SYNC_STAGES(2), .DATA_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi           (spi),
    .ch0_data      (ch0),
    .ch1_data      (ch1),
    .sample_strobe (sample_strobe),
    .cfg_sgl       (cfg_sgl),
    .cfg_odd       (cfg_odd),
    .cfg_msbf      (cfg_msbf),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] code;
    logic       sgl, odd, msbf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_done = 0, n_err = 0, n_strobe = 0;
  bit   en_seen = 1'b0;

  always @(negedge clk) begin
    if (frame_done)    n_done++;
    if (frame_err)     n_err++;
    if (sample_strobe) n_strobe++;
    if (spi.dout_en)   en_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_code(input logic [9:0] c0, c1, input logic sgl, odd);
    int d;
    if (sgl) return odd ? c1 : c0;
    d = odd ? (int'(c1) - int'(c0)) : (int'(c0) - int'(c1));
    return (d < 0) ? 10'd0 : d[9:0];
  endfunction

  // One sclk period at a 9-clk half period; dout sampled just before the rise.
  task automatic sclk_cycle(input logic d, output logic s);
    spi.din = d;
    repeat (9) @(negedge clk);
    s = spi.dout;
    spi.sclk = 1'b1;
    repeat (9) @(negedge clk);
    spi.sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] cmd, input int lead, input int nsclk,
                           input int chg_edge, input logic [9:0] chg_val,
                           output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    spi.cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int e = 1; e <= nsclk; e++) begin
      logic d, s;
      if (e <= lead)          d = 1'b0;
      else if (e - lead <= 4) d = cmd[4 - (e - lead)];
      else                    d = 1'b0;
      sclk_cycle(d, s);
      rx[e-1] = s;
      if (e == chg_edge) ch0 = chg_val;
    end
    spi.din = 1'b0;
    repeat (2) @(negedge clk);
    spi.cs = 1'b1;
  endtask

  // Push expectation, run the frame, then pop and compare what came back.
  task automatic do_frame(input string name, input logic [3:0] cmd, input int lead,
                          input int nsclk, input int ndata, input bit settle,
                          input int chg_edge, input logic [9:0] chg_val);
    exp_t        e;
    logic [31:0] rx;
    logic [9:0]  word;
    int          d0, e0, s0;
    e.sgl  = cmd[2];
    e.odd  = cmd[1];
    e.msbf = cmd[0];
    e.code = model_code(ch0, ch1, cmd[2], cmd[1]);
    exp_q.push_back(e);
    d0 = n_done; e0 = n_err; s0 = n_strobe;
    run_frame(cmd, lead, nsclk, chg_edge, chg_val, rx);
    e = exp_q.pop_front();
    check({name, "_null"}, 32'(rx[lead+4]), 32'd0);
    word = '0;
    for (int i = 0; i < ndata; i++) word[9-i] = rx[lead+5+i];
    check({name, "_msb_word"}, 32'(word), 32'(e.code & ~(10'h3FF >> ndata)));
    if (!e.msbf && ndata == 10) begin
      word = '0;
      for (int j = 1; j <= 9; j++) word[j] = rx[lead+14+j];
      check({name, "_lsb_word"}, 32'(word), 32'(e.code & 10'h3FE));
    end
    if (settle) begin
      check({name, "_en_hold"}, 32'(spi.dout_en), 32'd1);
      repeat (3) @(negedge clk);
      check({name, "_en_drop"}, 32'(spi.dout_en), 32'd0);
      repeat (3) @(negedge clk);
      check({name, "_cfg"}, 32'({cfg_sgl, cfg_odd, cfg_msbf}), 32'({e.sgl, e.odd, e.msbf}));
      check({name, "_done_cnt"}, 32'(n_done - d0), (ndata == 10) ? 32'd1 : 32'd0);
      check({name, "_err_cnt"}, 32'(n_err - e0), (ndata == 10) ? 32'd0 : 32'd1);
      check({name, "_strobe_cnt"}, 32'(n_strobe - s0), 32'd1);
    end
  endtask

  initial begin
    logic s;
    int   d0, e0, s0;
    rst = 1'b1;
    spi.cs = 1'b1; spi.sclk = 1'b0; spi.din = 1'b0;
    ch0 = 10'h2A5; ch1 = 10'h301;
    repeat (4) @(negedge clk);
    check("rst_outputs", 32'({spi.dout, spi.dout_en, sample_strobe, frame_done, frame_err}), 32'd0);
    check("rst_cfg", 32'({cfg_sgl, cfg_odd, cfg_msbf}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_frame("se_ch0_msbf", 4'b1101, 0, 16, 10, 1'b1, 0, '0);
    do_frame("se_ch1_lsbf", 4'b1110, 0, 24, 10, 1'b1, 0, '0);

    ch0 = 10'h100; ch1 = 10'h180;
    do_frame("diff_sat", 4'b1001, 0, 16, 10, 1'b1, 0, '0);
    do_frame("diff_pos", 4'b1011, 0, 16, 10, 1'b1, 0, '0);

    ch0 = 10'h2A5;
    do_frame("abort", 4'b1101, 3, 12, 4, 1'b1, 0, '0);
    ch0 = 10'h15C;
    do_frame("after_abort", 4'b1101, 0, 16, 10, 1'b1, 0, '0);

    // Reset in the middle of the data phase, then release with cs still low.
    @(negedge clk);
    spi.cs = 1'b0;
    repeat (3) @(negedge clk);
    sclk_cycle(1'b1, s); sclk_cycle(1'b1, s); sclk_cycle(1'b0, s); sclk_cycle(1'b1, s);
    sclk_cycle(1'b0, s); sclk_cycle(1'b0, s); sclk_cycle(1'b0, s);
    check("pre_rst_en", 32'(spi.dout_en), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({spi.dout, spi.dout_en, sample_strobe, frame_done, frame_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en_seen = 1'b0;
    s0 = n_strobe; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 16; i++) sclk_cycle((i < 4) ? 1'b1 : 1'b0, s);
    repeat (4) @(negedge clk);
    check("post_rst_silent_en", 32'(en_seen), 32'd0);
    check("post_rst_silent_pulses", 32'((n_strobe - s0) + (n_done - d0) + (n_err - e0)), 32'd0);
    spi.cs = 1'b1;
    do_frame("post_rst_frame", 4'b1101, 0, 16, 10, 1'b1, 0, '0);

    // Back-to-back streaming with ch0 changed after each capture.
    s0 = n_strobe; d0 = n_done; e0 = n_err;
    for (int k = 0; k < 100; k++) begin
      ch0 = 10'($urandom_range(0, 1023));
      do_frame("stream", 4'b1101, 0, 16, 10, 1'b0, 8, 10'($urandom_range(0, 1023)));
    end
    repeat (8) @(negedge clk);
    check("stream_done_cnt", 32'(n_done - d0), 32'd100);
    check("stream_err_cnt", 32'(n_err - e0), 32'd0);
    check("stream_strobe_cnt", 32'(n_strobe - s0), 32'd100);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
